// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - control FSM for the shared multicycle datapath
//
// Purpose: sequences one memory port, one ALU, IR, ALUOut and PC through
// fetch/decode/execute states. Memory accesses wait on mem_ready, bounded by
// a per-access timeout. Illegal opcodes and a hung bus end in a sticky TRAP
// state that only reset leaves.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct       IR[31:26] / IR[5:0]
//   zero                ALU zero flag (same cycle)
//   mem_ready           memory completes the current access this cycle
//   mem_read/mem_write  memory request strobes
//   iord                address select (0 PC, 1 ALUOut)
//   ir_write, pc_en     IR / PC load enables
//   pc_src              00 ALU, 01 ALUOut, 10 jump target
//   alu_src_a/b         ALU operand selects
//   alu_control         010 add, 110 sub, 000 and, 001 or, 111 slt
//   reg_write, reg_dst  register file write and destination (0 rt, 1 rd)
//   mem_to_reg, reg_src writeback source selects (MDR / special)
//   trap_cause          sticky: 00 none, 01 illegal opcode, 10 memory timeout
//   state               current state, for debug

module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_src,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEX   = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_MFC    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_MFC   = 6'b010000;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // A limit of zero disables the timeout entirely.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);
  localparam bit         TIMEOUT_ON    = (MEM_TIMEOUT != 0);

  logic [3:0] state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       in_wait;
  logic       timed_out;

  // Strobes before the reset gate.
  logic mem_read_c, mem_write_c, ir_write_c, pc_en_c, reg_write_c;

  assign in_wait   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  // mem_ready wins over an expiring count in the same cycle.
  assign timed_out = TIMEOUT_ON && in_wait && !mem_ready && (wait_cnt_q >= TIMEOUT_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      cause_q    <= CAUSE_NONE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_MFC:       state_d = S_MFC;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        // opcode is held stable since DECODE; anything but lw/sw here means
        // the IR changed under us, which is treated as illegal.
        if (opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (opcode == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_MFC:    state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default: begin
        // Unused encodings 14/15.
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  // Wait counter: counts stalled cycles of the current access, restarts on
  // every state change, saturates so a disabled timeout never wraps.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = 8'd0;
    end else if (in_wait && !mem_ready && (wait_cnt_q != 8'hFF)) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  // Output logic
  always_comb begin
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    iord        = 1'b0;
    ir_write_c  = 1'b0;
    pc_en_c     = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_write_c = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_src     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        // IR and PC+4 commit only in the cycle the read completes.
        ir_write_c  = mem_ready;
        pc_en_c     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read_c = 1'b1;
        iord       = 1'b1;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_c = 1'b1;
        iord        = 1'b1;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default:   alu_control = ALU_AND;
        endcase
      end
      S_RTWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en_c     = zero;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
      end
      S_JUMP: begin
        pc_src  = 2'b10;
        pc_en_c = 1'b1;
      end
      S_MFC: begin
        reg_write_c = 1'b1;
        reg_src     = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Reset puts the FSM in FETCH, which would otherwise request a read; the
  // strobes are masked so nothing reaches memory or state while rst_n is low.
  assign mem_read   = mem_read_c  & rst_n;
  assign mem_write  = mem_write_c & rst_n;
  assign ir_write   = ir_write_c  & rst_n;
  assign pc_en      = pc_en_c     & rst_n;
  assign reg_write  = reg_write_c & rst_n;

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed table-driven bench for multicycle_ctrl_fsm

module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_control;
  logic       reg_write, reg_dst, mem_to_reg, reg_src;
  logic [1:0] trap_cause;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_src(reg_src),
    .trap_cause(trap_cause), .state(state)
  );

  typedef struct {
    string      name;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] st;
    logic [16:0] outs;
    logic [1:0] trap;
  } vec_t;

  vec_t vecs[$];

  // {mem_read, mem_write, iord, ir_write, pc_en, pc_src, src_a, src_b, alu, reg_write, reg_dst, mem_to_reg, reg_src}
  function automatic logic [16:0] o(input logic mr, input logic mw, input logic io,
                                    input logic irw, input logic pce, input logic [1:0] pcs,
                                    input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                    input logic rw, input logic rd, input logic m2r, input logic rs);
    return {mr, mw, io, irw, pce, pcs, sa, sb, alu, rw, rd, m2r, rs};
  endfunction

  function automatic vec_t mkv(input string name, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy, input logic [3:0] st,
                               input logic [16:0] outs, input logic [1:0] trap);
    vec_t v;
    v.name = name; v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = rdy;
    v.st = st; v.outs = outs; v.trap = trap;
    return v;
  endfunction

  function automatic logic [16:0] dut_outs();
    return {mem_read, mem_write, iord, ir_write, pc_en, pc_src, alu_src_a, alu_src_b,
            alu_control, reg_write, reg_dst, mem_to_reg, reg_src};
  endfunction

  task automatic check(input string name, input logic [3:0] st, input logic [16:0] outs,
                       input logic [1:0] trap);
    checks++;
    if ({state, dut_outs(), trap_cause} !== {st, outs, trap}) begin
      failures++;
      $display("FAIL %s: got state=%0d outs=%05h trap=%0d, required state=%0d outs=%05h trap=%0d",
               name, state, dut_outs(), trap_cause, st, outs, trap);
    end
  endtask

  // Entered at a falling edge: drive, settle, compare, then move to the next falling edge.
  task automatic apply(input vec_t v);
    opcode = v.opcode; funct = v.funct; zero = v.zero; mem_ready = v.mem_ready;
    #1;
    check(v.name, v.st, v.outs, v.trap);
    @(negedge clk);
  endtask

  logic [16:0] F1, F0, FRST, DEC, MADR, MRD, MWB, MWR, RTWB, AEX, AWB, JMP, MFCO, NONE;

  function automatic logic [16:0] rtex(input logic [2:0] alu);
    return o(0,0,0,0,0,2'b00,1,2'b00,alu,0,0,0,0);
  endfunction

  function automatic logic [16:0] beqo(input logic z);
    return o(0,0,0,0,z,2'b01,1,2'b00,3'b110,0,0,0,0);
  endfunction

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000, JJ = 6'b000010, MF = 6'b010000, BAD = 6'b111111;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    F1   = o(1,0,0,1,1,2'b00,0,2'b01,3'b010,0,0,0,0);
    F0   = o(1,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0);
    FRST = o(0,0,0,0,0,2'b00,0,2'b01,3'b010,0,0,0,0);
    DEC  = o(0,0,0,0,0,2'b00,0,2'b11,3'b010,0,0,0,0);
    MADR = o(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
    MRD  = o(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    MWB  = o(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0);
    MWR  = o(0,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0);
    RTWB = o(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,1,0,0);
    AEX  = o(0,0,0,0,0,2'b00,1,2'b10,3'b010,0,0,0,0);
    AWB  = o(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,0);
    JMP  = o(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,0);
    MFCO = o(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,0,1);
    NONE = 17'd0;

    // R add: 0,1,6,7
    vecs.push_back(mkv("radd_fetch",  R, 6'b100000, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("radd_decode", R, 6'b100000, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("radd_rtex",   R, 6'b100000, 0, 1, 6, rtex(3'b010), 0));
    vecs.push_back(mkv("radd_rtwb",   R, 6'b100000, 0, 1, 7, RTWB, 0));
    // R sub / slt / unknown funct (and)
    vecs.push_back(mkv("rsub_fetch",  R, 6'b100010, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("rsub_decode", R, 6'b100010, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("rsub_rtex",   R, 6'b100010, 0, 1, 6, rtex(3'b110), 0));
    vecs.push_back(mkv("rsub_rtwb",   R, 6'b100010, 0, 1, 7, RTWB, 0));
    vecs.push_back(mkv("rslt_fetch",  R, 6'b101010, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("rslt_decode", R, 6'b101010, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("rslt_rtex",   R, 6'b101010, 0, 1, 6, rtex(3'b111), 0));
    vecs.push_back(mkv("rslt_rtwb",   R, 6'b101010, 0, 1, 7, RTWB, 0));
    vecs.push_back(mkv("ror_fetch",   R, 6'b100101, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("ror_decode",  R, 6'b100101, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("ror_rtex",    R, 6'b100101, 0, 1, 6, rtex(3'b001), 0));
    vecs.push_back(mkv("ror_rtwb",    R, 6'b100101, 0, 1, 7, RTWB, 0));
    vecs.push_back(mkv("runk_fetch",  R, 6'b000111, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("runk_decode", R, 6'b000111, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("runk_rtex",   R, 6'b000111, 0, 1, 6, rtex(3'b000), 0));
    vecs.push_back(mkv("runk_rtwb",   R, 6'b000111, 0, 1, 7, RTWB, 0));
    // lw with 3 stalled MEMRD cycles: 8 cycles total
    vecs.push_back(mkv("lw_fetch",    LW, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("lw_decode",   LW, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("lw_memadr",   LW, 0, 0, 1, 2, MADR, 0));
    vecs.push_back(mkv("lw_memrd_w1", LW, 0, 0, 0, 3, MRD, 0));
    vecs.push_back(mkv("lw_memrd_w2", LW, 0, 0, 0, 3, MRD, 0));
    vecs.push_back(mkv("lw_memrd_w3", LW, 0, 0, 0, 3, MRD, 0));
    vecs.push_back(mkv("lw_memrd_ok", LW, 0, 0, 1, 3, MRD, 0));
    vecs.push_back(mkv("lw_memwb",    LW, 0, 0, 1, 4, MWB, 0));
    // sw
    vecs.push_back(mkv("sw_fetch",    SW, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("sw_decode",   SW, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("sw_memadr",   SW, 0, 0, 1, 2, MADR, 0));
    vecs.push_back(mkv("sw_memwr",    SW, 0, 0, 1, 5, MWR, 0));
    // addi
    vecs.push_back(mkv("addi_fetch",  AI, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("addi_decode", AI, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("addi_ex",     AI, 0, 0, 1, 9, AEX, 0));
    vecs.push_back(mkv("addi_wb",     AI, 0, 0, 1, 10, AWB, 0));
    // beq taken then not taken
    vecs.push_back(mkv("beq1_fetch",  BQ, 0, 1, 1, 0, F1, 0));
    vecs.push_back(mkv("beq1_decode", BQ, 0, 1, 1, 1, DEC, 0));
    vecs.push_back(mkv("beq1_taken",  BQ, 0, 1, 1, 8, beqo(1), 0));
    vecs.push_back(mkv("beq0_fetch",  BQ, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("beq0_decode", BQ, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("beq0_not",    BQ, 0, 0, 1, 8, beqo(0), 0));
    // mfc
    vecs.push_back(mkv("mfc_fetch",   MF, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("mfc_decode",  MF, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("mfc_exec",    MF, 0, 0, 1, 12, MFCO, 0));
    // j with FETCH stalled until the timeout cycle itself: mem_ready wins
    vecs.push_back(mkv("j_fetch_w1",  JJ, 0, 0, 0, 0, F0, 0));
    vecs.push_back(mkv("j_fetch_w2",  JJ, 0, 0, 0, 0, F0, 0));
    vecs.push_back(mkv("j_fetch_w3",  JJ, 0, 0, 0, 0, F0, 0));
    vecs.push_back(mkv("j_fetch_w4",  JJ, 0, 0, 0, 0, F0, 0));
    vecs.push_back(mkv("j_fetch_lim", JJ, 0, 0, 1, 0, F1, 0));
    vecs.push_back(mkv("j_decode",    JJ, 0, 0, 1, 1, DEC, 0));
    vecs.push_back(mkv("j_jump",      JJ, 0, 0, 1, 11, JMP, 0));
    vecs.push_back(mkv("back_fetch",  R, 0, 0, 0, 0, F0, 0));

    // Reset: strobes masked while low even with mem_ready high
    rst_n = 1'b0; opcode = R; funct = 0; zero = 0; mem_ready = 1'b1;
    @(negedge clk);
    #1 check("reset_hold", 0, FRST, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Recover to a clean FETCH at a falling edge
    rst_n = 1'b0; #1; rst_n = 1'b1;
    @(negedge clk);

    // Illegal opcode -> TRAP cause 01, strobes quiet for 20 cycles
    apply(mkv("ill_fetch",  BAD, 0, 0, 1, 0, F1, 0));
    apply(mkv("ill_decode", BAD, 0, 0, 1, 1, DEC, 0));
    for (int i = 0; i < 20; i++) apply(mkv("ill_trap", BAD, 0, 1, 1, 13, NONE, 2'b01));
    rst_n = 1'b0;
    #1 check("ill_reset", 0, FRST, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // mem_ready stuck low in FETCH: TRAP cause 10 after the 5th FETCH cycle
    for (int i = 0; i < 5; i++) apply(mkv("to_fetch", R, 0, 0, 0, 0, F0, 0));
    apply(mkv("to_trap",      R, 0, 0, 0, 13, NONE, 2'b10));
    apply(mkv("to_trap_rdy",  R, 0, 0, 1, 13, NONE, 2'b10));
    rst_n = 1'b0;
    #1 check("to_reset", 0, FRST, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-MEMWR: mem_write drops at once, then sw completes in 4 cycles
    apply(mkv("rsw_fetch",  SW, 0, 0, 1, 0, F1, 0));
    apply(mkv("rsw_decode", SW, 0, 0, 1, 1, DEC, 0));
    apply(mkv("rsw_memadr", SW, 0, 0, 1, 2, MADR, 0));
    apply(mkv("rsw_memwr",  SW, 0, 0, 0, 5, MWR, 0));
    #2 rst_n = 1'b0;
    #1 check("rsw_async", 0, FRST, 0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mkv("sw2_fetch",  SW, 0, 0, 1, 0, F1, 0));
    apply(mkv("sw2_decode", SW, 0, 0, 1, 1, DEC, 0));
    apply(mkv("sw2_memadr", SW, 0, 0, 1, 2, MADR, 0));
    apply(mkv("sw2_memwr",  SW, 0, 0, 1, 5, MWR, 0));
    apply(mkv("sw2_done",   SW, 0, 0, 0, 0, F0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
